// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the five-stage pipeline. It decides whether
// each inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds or takes
// a bubble. It also sequences halt and cache-flush ops through a small FSM
// (RUN -> DRAIN -> CFLUSH/HALTED).
// Optional feature macro: FORWARDING_EN. When it is defined, only load-use and a
// busy matmul stall decode. When it is undefined, any EX/MEM writer match stalls.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_rs1_en_i,
   input  logic                  id_rs2_en_i,
   input  logic [REG_ADDR_W-1:0] id_vs1_i,
   input  logic [REG_ADDR_W-1:0] id_vs2_i,
   input  logic                  id_vs1_en_i,
   input  logic                  id_vs2_en_i,
   input  logic                  id_halt_i,
   input  logic                  id_iflush_i,
   input  logic                  id_dflush_i,
   input  logic                  id_mm_en_i,
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_reg_wr_i,
   input  logic                  ex_vec_wr_i,
   input  logic [REG_ADDR_W-1:0] ex_wr_reg_i,
   input  logic                  mem_valid_i,
   input  logic                  mem_reg_wr_i,
   input  logic                  mem_vec_wr_i,
   input  logic [REG_ADDR_W-1:0] mem_wr_reg_i,
   input  logic                  ex_redirect_i,
   input  logic                  icache_stall_i,
   input  logic                  dcache_stall_i,
   input  logic                  mm_busy_i,
   input  logic                  cflush_ack_i,
   output logic                  pc_hold_o,
   output logic                  ifid_hold_o,
   output logic                  ifid_flush_o,
   output logic                  idex_hold_o,
   output logic                  idex_flush_o,
   output logic                  exmem_hold_o,
   output logic                  memwb_bubble_o,
   output logic                  iflush_req_o,
   output logic                  dflush_req_o,
   output logic                  halted_o
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_CFLUSH = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   // Scalar register 0 is hard-wired zero, so it never carries a dependence.
   function automatic logic scalar_hit(input logic en,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] dst);
      return en && (src != {REG_ADDR_W{1'b0}}) && (src == dst);
   endfunction

   // Vector registers have no zero register; every index is real.
   function automatic logic vector_hit(input logic en,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] dst);
      return en && (src == dst);
   endfunction

   state_e state_q, state_d, cur_state_s;
   logic   op_halt_q, op_halt_d;
   logic   op_iflush_q, op_iflush_d;
   logic   op_dflush_q, op_dflush_d;
   logic   iflush_req_q, iflush_req_d;
   logic   dflush_req_q, dflush_req_d;

   logic   ex_s_hit_s, ex_v_hit_s, load_use_s, mm_stall_s, raw_s;
   logic   hazard_s, special_s;
   logic   pc_hold_s, ifid_hold_s, ifid_flush_s, idex_hold_s, idex_flush_s;
   logic   exmem_hold_s, memwb_bubble_s;

   assign ex_s_hit_s = ex_valid_i & ex_reg_wr_i &
                       (scalar_hit(id_rs1_en_i, id_rs1_i, ex_wr_reg_i) |
                        scalar_hit(id_rs2_en_i, id_rs2_i, ex_wr_reg_i));
   assign ex_v_hit_s = ex_valid_i & ex_vec_wr_i &
                       (vector_hit(id_vs1_en_i, id_vs1_i, ex_wr_reg_i) |
                        vector_hit(id_vs2_en_i, id_vs2_i, ex_wr_reg_i));
   assign load_use_s = ex_mem_read_i & (ex_s_hit_s | ex_v_hit_s);
   assign mm_stall_s = id_mm_en_i & mm_busy_i;

`ifdef FORWARDING_EN
   // Forwarding covers every RAW except a load result that is not ready yet.
   assign raw_s = load_use_s;
`else
   logic mem_s_hit_s, mem_v_hit_s;
   assign mem_s_hit_s = mem_valid_i & mem_reg_wr_i &
                        (scalar_hit(id_rs1_en_i, id_rs1_i, mem_wr_reg_i) |
                         scalar_hit(id_rs2_en_i, id_rs2_i, mem_wr_reg_i));
   assign mem_v_hit_s = mem_valid_i & mem_vec_wr_i &
                        (vector_hit(id_vs1_en_i, id_vs1_i, mem_wr_reg_i) |
                         vector_hit(id_vs2_en_i, id_vs2_i, mem_wr_reg_i));
   assign raw_s = load_use_s | ex_s_hit_s | ex_v_hit_s | mem_s_hit_s | mem_v_hit_s;
`endif

   assign hazard_s  = id_valid_i & (raw_s | mm_stall_s);
   assign special_s = id_valid_i & (id_halt_i | id_iflush_i | id_dflush_i);

   // While reset is asserted, the stage controls decode as if the FSM were in RUN.
   assign cur_state_s = rst_i ? ST_RUN : state_q;

   // Next-state and stage-control decode.
   always_comb begin
      state_d        = state_q;
      op_halt_d      = op_halt_q;
      op_iflush_d    = op_iflush_q;
      op_dflush_d    = op_dflush_q;
      iflush_req_d   = iflush_req_q;
      dflush_req_d   = dflush_req_q;
      pc_hold_s      = 1'b0;
      ifid_hold_s    = 1'b0;
      ifid_flush_s   = 1'b0;
      idex_hold_s    = 1'b0;
      idex_flush_s   = 1'b0;
      exmem_hold_s   = 1'b0;
      memwb_bubble_s = 1'b0;
      case (cur_state_s)
         ST_RUN: begin
            if (dcache_stall_i) begin
               pc_hold_s      = 1'b1;
               ifid_hold_s    = 1'b1;
               idex_hold_s    = 1'b1;
               exmem_hold_s   = 1'b1;
               memwb_bubble_s = 1'b1;
            end else if (ex_redirect_i) begin
               // Squash the two younger ops in IF/ID and ID/EX; PC takes the new target.
               ifid_flush_s = 1'b1;
               idex_flush_s = 1'b1;
            end else if (icache_stall_i) begin
               pc_hold_s    = 1'b1;
               ifid_flush_s = 1'b1;
            end else if (hazard_s) begin
               pc_hold_s    = 1'b1;
               ifid_hold_s  = 1'b1;
               idex_flush_s = 1'b1;
            end else if (special_s) begin
               // Park the halt/flush op in IF/ID until the back end is empty.
               pc_hold_s    = 1'b1;
               ifid_hold_s  = 1'b1;
               idex_flush_s = 1'b1;
               op_halt_d    = id_halt_i;
               op_iflush_d  = id_iflush_i;
               op_dflush_d  = id_dflush_i;
               state_d      = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (dcache_stall_i) begin
               // The back end is frozen, so any redirect waits until the miss resolves.
               pc_hold_s      = 1'b1;
               ifid_hold_s    = 1'b1;
               idex_hold_s    = 1'b1;
               exmem_hold_s   = 1'b1;
               memwb_bubble_s = 1'b1;
            end else if (ex_redirect_i) begin
               // An older branch squashes the parked op.
               ifid_flush_s = 1'b1;
               idex_flush_s = 1'b1;
               op_halt_d    = 1'b0;
               op_iflush_d  = 1'b0;
               op_dflush_d  = 1'b0;
               state_d      = ST_RUN;
            end else begin
               pc_hold_s    = 1'b1;
               ifid_hold_s  = 1'b1;
               idex_flush_s = 1'b1;
               if (!ex_valid_i && !mem_valid_i) begin
                  if (op_halt_q) begin
                     state_d = ST_HALTED;
                  end else begin
                     iflush_req_d = op_iflush_q;
                     dflush_req_d = op_dflush_q;
                     state_d      = ST_CFLUSH;
                  end
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_CFLUSH: begin
            if (cflush_ack_i) begin
               // Retire the flush op. PC stays held so the op fetched behind it survives.
               pc_hold_s    = 1'b1;
               ifid_flush_s = 1'b1;
               idex_flush_s = 1'b1;
               iflush_req_d = 1'b0;
               dflush_req_d = 1'b0;
               op_iflush_d  = 1'b0;
               op_dflush_d  = 1'b0;
               state_d      = ST_RUN;
            end else begin
               pc_hold_s    = 1'b1;
               ifid_hold_s  = 1'b1;
               idex_flush_s = 1'b1;
            end
         end
         ST_HALTED: begin
            pc_hold_s    = 1'b1;
            ifid_hold_s  = 1'b1;
            idex_flush_s = 1'b1;
         end
         default: begin
            pc_hold_s    = 1'b1;
            ifid_hold_s  = 1'b1;
            idex_flush_s = 1'b1;
            state_d      = ST_RUN;
         end
      endcase
   end

   // State, captured op kind and flush-request registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         op_halt_q    <= 1'b0;
         op_iflush_q  <= 1'b0;
         op_dflush_q  <= 1'b0;
         iflush_req_q <= 1'b0;
         dflush_req_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_halt_q    <= op_halt_d;
         op_iflush_q  <= op_iflush_d;
         op_dflush_q  <= op_dflush_d;
         iflush_req_q <= iflush_req_d;
         dflush_req_q <= dflush_req_d;
      end
   end

   assign pc_hold_o      = pc_hold_s;
   assign ifid_hold_o    = ifid_hold_s;
   assign ifid_flush_o   = ifid_flush_s;
   assign idex_hold_o    = idex_hold_s;
   assign idex_flush_o   = idex_flush_s;
   assign exmem_hold_o   = exmem_hold_s;
   assign memwb_bubble_o = memwb_bubble_s;
   assign iflush_req_o   = iflush_req_q;
   assign dflush_req_o   = dflush_req_q;
   assign halted_o       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl.
// Each control vector is packed as
// {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold,
//  memwb_bubble, iflush_req, dflush_req, halted}.
module tb_pipeline_hazard_ctrl;
   localparam int W = 5;
   localparam logic [9:0] NONE   = 10'b0000000000;
   localparam logic [9:0] HAZ    = 10'b1100100000;
   localparam logic [9:0] DC     = 10'b1101011000;
   localparam logic [9:0] REDIR  = 10'b0010100000;
   localparam logic [9:0] ICS    = 10'b1010000000;
   localparam logic [9:0] CF_D   = 10'b1100100010;
   localparam logic [9:0] ACK_D  = 10'b1010100010;
   localparam logic [9:0] CF_I   = 10'b1100100100;
   localparam logic [9:0] HALT   = 10'b1100100001;
`ifdef FORWARDING_EN
   localparam logic [9:0] RAW_EXP = NONE;
`else
   localparam logic [9:0] RAW_EXP = HAZ;
`endif

   logic clk, rst;
   logic id_valid, id_rs1_en, id_rs2_en, id_vs1_en, id_vs2_en;
   logic [W-1:0] id_rs1, id_rs2, id_vs1, id_vs2, ex_wr_reg, mem_wr_reg;
   logic id_halt, id_iflush, id_dflush, id_mm_en;
   logic ex_valid, ex_mem_read, ex_reg_wr, ex_vec_wr;
   logic mem_valid, mem_reg_wr, mem_vec_wr;
   logic ex_redirect, icache_stall, dcache_stall, mm_busy, cflush_ack;
   logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble;
   logic iflush_req, dflush_req, halted;
   logic [9:0] ctl;
   int tests = 0;
   int fails = 0;

   assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold,
                 memwb_bubble, iflush_req, dflush_req, halted};

   pipeline_hazard_ctrl #(.REG_ADDR_W(W)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_rs1_en_i(id_rs1_en), .id_rs2_en_i(id_rs2_en),
      .id_vs1_i(id_vs1), .id_vs2_i(id_vs2), .id_vs1_en_i(id_vs1_en), .id_vs2_en_i(id_vs2_en),
      .id_halt_i(id_halt), .id_iflush_i(id_iflush), .id_dflush_i(id_dflush), .id_mm_en_i(id_mm_en),
      .ex_valid_i(ex_valid), .ex_mem_read_i(ex_mem_read), .ex_reg_wr_i(ex_reg_wr),
      .ex_vec_wr_i(ex_vec_wr), .ex_wr_reg_i(ex_wr_reg),
      .mem_valid_i(mem_valid), .mem_reg_wr_i(mem_reg_wr), .mem_vec_wr_i(mem_vec_wr),
      .mem_wr_reg_i(mem_wr_reg),
      .ex_redirect_i(ex_redirect), .icache_stall_i(icache_stall), .dcache_stall_i(dcache_stall),
      .mm_busy_i(mm_busy), .cflush_ack_i(cflush_ack),
      .pc_hold_o(pc_hold), .ifid_hold_o(ifid_hold), .ifid_flush_o(ifid_flush),
      .idex_hold_o(idex_hold), .idex_flush_o(idex_flush), .exmem_hold_o(exmem_hold),
      .memwb_bubble_o(memwb_bubble), .iflush_req_o(iflush_req), .dflush_req_o(dflush_req),
      .halted_o(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_en = 1'b0; id_rs2_en = 1'b0;
      id_vs1 = '0; id_vs2 = '0; id_vs1_en = 1'b0; id_vs2_en = 1'b0;
      id_halt = 1'b0; id_iflush = 1'b0; id_dflush = 1'b0; id_mm_en = 1'b0;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_reg_wr = 1'b0; ex_vec_wr = 1'b0; ex_wr_reg = '0;
      mem_valid = 1'b0; mem_reg_wr = 1'b0; mem_vec_wr = 1'b0; mem_wr_reg = '0;
      ex_redirect = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0; mm_busy = 1'b0;
      cflush_ack = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Load in EX writing x3, decode reads x3.
   task automatic set_load_use();
      id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_en = 1'b1;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_wr = 1'b1; ex_wr_reg = 5'd3;
   endtask

   task automatic test_reset();
      idle(); rst = 1'b1; next_cycle(); #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL reset_idle: got %b expected %b", ctl, NONE); end
      set_load_use(); #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL reset_run_decode: got %b expected %b", ctl, HAZ); end
      idle(); rst = 1'b0; next_cycle(); #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL reset_release: got %b expected %b", ctl, NONE); end
   endtask

   task automatic test_load_use();
      idle(); set_load_use(); #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL load_use: got %b expected %b", ctl, HAZ); end
      next_cycle(); idle(); id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_en = 1'b1; #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL load_use_one_bubble: got %b expected %b", ctl, NONE); end
      idle(); set_load_use(); id_rs1 = 5'd0; ex_wr_reg = 5'd0; #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL load_use_x0: got %b expected %b", ctl, NONE); end
      idle(); id_valid = 1'b1; id_vs2 = 5'd5; id_vs2_en = 1'b1;
      ex_valid = 1'b1; ex_vec_wr = 1'b1; ex_wr_reg = 5'd5; #1;
      tests++; if (ctl !== RAW_EXP) begin fails++; $display("FAIL vec_raw_ex: got %b expected %b", ctl, RAW_EXP); end
      ex_mem_read = 1'b1; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL vec_load_use: got %b expected %b", ctl, HAZ); end
      idle(); id_valid = 1'b1; mm_busy = 1'b1; #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL mm_busy_no_op: got %b expected %b", ctl, NONE); end
      id_mm_en = 1'b1; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL mm_busy_stall: got %b expected %b", ctl, HAZ); end
      next_cycle(); idle();
   endtask

   task automatic test_mem_raw();
      idle(); id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_en = 1'b1;
      mem_valid = 1'b1; mem_reg_wr = 1'b1; mem_wr_reg = 5'd7; #1;
      tests++; if (ctl !== RAW_EXP) begin fails++; $display("FAIL mem_raw: got %b expected %b", ctl, RAW_EXP); end
      next_cycle(); mem_valid = 1'b0; #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL mem_raw_release: got %b expected %b", ctl, NONE); end
      idle();
   endtask

   task automatic test_redirect();
      idle(); set_load_use(); ex_redirect = 1'b1; icache_stall = 1'b1; #1;
      tests++; if (ctl !== REDIR) begin fails++; $display("FAIL redirect_over_icache: got %b expected %b", ctl, REDIR); end
      idle(); icache_stall = 1'b1; #1;
      tests++; if (ctl !== ICS) begin fails++; $display("FAIL icache_stall: got %b expected %b", ctl, ICS); end
      next_cycle(); idle();
   endtask

   task automatic test_dcache();
      idle(); set_load_use(); dcache_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (ctl !== DC) begin fails++; $display("FAIL dcache_cycle%0d: got %b expected %b", i, ctl, DC); end
         next_cycle();
      end
      dcache_stall = 1'b0; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL dcache_then_hazard: got %b expected %b", ctl, HAZ); end
      next_cycle(); ex_valid = 1'b0; ex_mem_read = 1'b0; ex_reg_wr = 1'b0; #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL dcache_then_run: got %b expected %b", ctl, NONE); end
      idle();
   endtask

   task automatic test_dflush();
      idle(); id_valid = 1'b1; id_dflush = 1'b1; ex_valid = 1'b1; mem_valid = 1'b1; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL dflush_enter: got %b expected %b", ctl, HAZ); end
      next_cycle(); ex_valid = 1'b0; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL dflush_drain1: got %b expected %b", ctl, HAZ); end
      next_cycle(); mem_valid = 1'b0; cflush_ack = 1'b1; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL dflush_drain2: got %b expected %b", ctl, HAZ); end
      next_cycle(); cflush_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (ctl !== CF_D) begin fails++; $display("FAIL dflush_req_cycle%0d: got %b expected %b", i, ctl, CF_D); end
         next_cycle();
      end
      cflush_ack = 1'b1; #1;
      tests++; if (ctl !== ACK_D) begin fails++; $display("FAIL dflush_ack: got %b expected %b", ctl, ACK_D); end
      next_cycle(); idle(); #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL dflush_back_to_run: got %b expected %b", ctl, NONE); end
   endtask

   task automatic test_iflush_reset();
      idle(); id_valid = 1'b1; id_iflush = 1'b1; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL iflush_enter: got %b expected %b", ctl, HAZ); end
      next_cycle(); #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL iflush_drain: got %b expected %b", ctl, HAZ); end
      next_cycle(); #1;
      tests++; if (ctl !== CF_I) begin fails++; $display("FAIL iflush_req: got %b expected %b", ctl, CF_I); end
      next_cycle(); idle(); rst = 1'b1; #1;
      tests++; if (ctl !== 10'b0000000100) begin fails++; $display("FAIL iflush_rst_cycle: got %b expected %b", ctl, 10'b0000000100); end
      next_cycle(); rst = 1'b0; #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL iflush_after_rst: got %b expected %b", ctl, NONE); end
   endtask

   task automatic test_halt();
      idle(); id_valid = 1'b1; id_halt = 1'b1; ex_valid = 1'b1; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL halt_enter: got %b expected %b", ctl, HAZ); end
      next_cycle(); ex_redirect = 1'b1; #1;
      tests++; if (ctl !== REDIR) begin fails++; $display("FAIL halt_squash: got %b expected %b", ctl, REDIR); end
      next_cycle(); idle(); #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL halt_squashed_run: got %b expected %b", ctl, NONE); end
      id_valid = 1'b1; id_halt = 1'b1; #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL halt_enter2: got %b expected %b", ctl, HAZ); end
      next_cycle(); #1;
      tests++; if (ctl !== HAZ) begin fails++; $display("FAIL halt_drain: got %b expected %b", ctl, HAZ); end
      next_cycle(); idle(); ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (ctl !== HALT) begin fails++; $display("FAIL halted_cycle%0d: got %b expected %b", i, ctl, HALT); end
         next_cycle();
      end
      idle(); rst = 1'b1; #1;
      tests++; if (ctl !== 10'b0000000001) begin fails++; $display("FAIL halt_rst_cycle: got %b expected %b", ctl, 10'b0000000001); end
      next_cycle(); rst = 1'b0; #1;
      tests++; if (ctl !== NONE) begin fails++; $display("FAIL halt_after_rst: got %b expected %b", ctl, NONE); end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_load_use();
      test_mem_raw();
      test_redirect();
      test_dcache();
      test_dflush();
      test_iflush_reset();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
